// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer: counts edge strobes over GATE_CYCLES clocks, then holds the count under valid/ready.
// Optional `AUTO_RESTART_EN selects continuous back-to-back windows instead of single-shot.
module freq_gate_ctrl #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned GATE_W      = 26,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             edge_in,
  input  logic             freq_ready,
  output logic             busy,
  output logic             gate_o,
  output logic [CNT_W-1:0] freq_o,
  output logic             freq_valid,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [GATE_W-1:0] TIMER_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  logic [1:0]        state_q, state_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path can infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        cnt_d   = '0;
        sat_d   = 1'b0;
        timer_d = TIMER_LOAD;
        state_d = S_GATE;
      end
      S_GATE: begin
        // Saturation flag records that at least one edge was lost at full scale.
        if (edge_in) begin
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
        end
        timer_d = timer_q - 1'b1;
        if (timer_q == '0) begin
          timer_d = '0;
          state_d = S_DONE;
          freq_d  = cnt_d;
          ovf_d   = sat_d;
        end
      end
      S_DONE: begin
        if (freq_ready) begin
`ifdef AUTO_RESTART_EN
          state_d = S_ARM;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything and never publishes a partial window.
    if (abort) begin
      state_d = S_IDLE;
      freq_d  = freq_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign gate_o     = (state_q == S_GATE);
  assign freq_valid = (state_q == S_DONE);
  assign freq_o     = freq_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: a 32-bit and a 3-bit counter instance share stimulus,
// expected results are derived from window positions relative to the start pulse.
module tb_freq_gate_ctrl;

  localparam int GC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        edge_in = 1'b0;
  logic        freq_ready = 1'b0;

  logic        busy, gate_o, freq_valid, overflow;
  logic [31:0] freq_o;
  logic        busy3, gate3, valid3, ovf3;
  logic [2:0]  freq3;

  int errors = 0;
  int checks = 0;

  // Reference: last published result for each counter width
  int exp_freq  = 0;
  bit exp_ovf   = 1'b0;
  int exp_freq3 = 0;
  bit exp_ovf3  = 1'b0;

  always #5 clk = ~clk;

  freq_gate_ctrl #(.GATE_CYCLES(GC), .GATE_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .edge_in(edge_in),
    .freq_ready(freq_ready), .busy(busy), .gate_o(gate_o), .freq_o(freq_o),
    .freq_valid(freq_valid), .overflow(overflow)
  );

  freq_gate_ctrl #(.GATE_CYCLES(GC), .GATE_W(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .edge_in(edge_in),
    .freq_ready(freq_ready), .busy(busy3), .gate_o(gate3), .freq_o(freq3),
    .freq_valid(valid3), .overflow(ovf3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_result(input int n);
    exp_freq  = n;
    exp_ovf   = 1'b0;
    exp_freq3 = (n > 7) ? 7 : n;
    exp_ovf3  = (n > 7);
  endtask

  task automatic check_outputs(input string tag, input bit eb, input bit eg, input bit ev);
    check({tag, ".busy"},   32'(busy),       32'(eb));
    check({tag, ".gate"},   32'(gate_o),     32'(eg));
    check({tag, ".valid"},  32'(freq_valid), 32'(ev));
    check({tag, ".freq"},   freq_o,          exp_freq);
    check({tag, ".ovf"},    32'(overflow),   32'(exp_ovf));
    check({tag, ".busy3"},  32'(busy3),      32'(eb));
    check({tag, ".valid3"}, 32'(valid3),     32'(ev));
    check({tag, ".freq3"},  32'(freq3),      exp_freq3);
    check({tag, ".ovf3"},   32'(ovf3),       32'(exp_ovf3));
  endtask

  // Relative cycle 0 carries start; 1 is ARM; 2..GC+1 is the window; GC+2 is first DONE.
  // Bit k of e is edge_in during relative cycle k. noise adds ignored start/freq_ready pulses.
  task automatic measure(input string tag, input logic [15:0] e, input int hold, input bit noise);
    int n = 0;
    for (int k = 2; k <= GC + 1; k++) n += int'(e[k]);
    for (int k = 0; k <= GC + 1; k++) begin
      start      = (k == 0) || (noise && k >= 1 && $urandom_range(1) == 1);
      freq_ready = noise && k >= 1 && $urandom_range(1) == 1;
      edge_in    = e[k];
      check_outputs($sformatf("%s.c%0d", tag, k), k >= 1, k >= 2, 1'b0);
      step();
    end
    start      = 1'b0;
    freq_ready = 1'b0;
    set_result(n);
    for (int h = 0; h <= hold; h++) begin
      edge_in = (h == 0) ? e[GC + 2] : 1'($urandom_range(1));
      check_outputs($sformatf("%s.done%0d", tag, h), 1'b1, 1'b0, 1'b1);
      step();
    end
    freq_ready = 1'b1;
    edge_in    = 1'b0;
    step();
    freq_ready = 1'b0;
`ifdef AUTO_RESTART_EN
    check_outputs({tag, ".rearm"}, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif
    check_outputs({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Power-on reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_outputs("por", 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-window discards everything
    measure("pre", 16'h1FFF, 0, 1'b0);
    start = 1'b1;
    step();
    start   = 1'b0;
    edge_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_outputs("midgate", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n   = 1'b1;
    edge_in = 1'b0;
    set_result(0);
    check_outputs("rst", 1'b0, 1'b0, 1'b0);

    // Edge every 2nd cycle from start, result held 20 cycles
    measure("alt", 16'h1555, 20, 1'b0);
    check("alt.freq5", freq_o, 32'd5);

    // Edges on ARM, first gate, last gate and first DONE cycles: only two count
    measure("bound", 16'h1806, 2, 1'b0);

    // Saturation on the 3-bit instance, then a clean run clears overflow
    measure("sat", 16'h1FFF, 1, 1'b0);
    check("sat.freq3_7", 32'(freq3), 32'd7);
    measure("unsat", 16'h00A8, 1, 1'b0);

    // Restore a result of 5, then abort at the 5th gate cycle
    measure("five", 16'h1555, 0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_outputs("gate5", 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_outputs("abort", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      edge_in = 1'($urandom_range(1));
      step();
      check_outputs($sformatf("post_abort%0d", i), 1'b0, 1'b0, 1'b0);
    end
    edge_in = 1'b0;
    start   = 1'b1;
    abort   = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_outputs("abort_start", 1'b0, 1'b0, 1'b0);
    step();
    check_outputs("abort_start2", 1'b0, 1'b0, 1'b0);

    // Randomized windows with ignored start/freq_ready noise
    for (int r = 0; r < 8; r++) begin
      measure($sformatf("rnd%0d", r), 16'($urandom), int'($urandom_range(4)), 1'b1);
    end

`ifdef AUTO_RESTART_EN
    // Continuous mode: results every GC+2 cycles while freq_ready stays high
    edge_in    = 1'b1;
    freq_ready = 1'b1;
    start      = 1'b1;
    for (int c = 0; c <= 3 * (GC + 2) + 2; c++) begin
      if (c == GC + 2) set_result(GC);
      check_outputs($sformatf("auto.c%0d", c), c >= 1, c >= 1 && (c % (GC + 2)) >= 2,
                    c >= 1 && (c % (GC + 2)) == 0);
      step();
      start = 1'b0;
    end
    abort = 1'b1;
    step();
    abort      = 1'b0;
    freq_ready = 1'b0;
    edge_in    = 1'b0;
    check_outputs("auto.abort", 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
